mem_init_arb: RTL and testbench

//  Sequences a single-port synchronous memory after reset, then shares it between two requesters.
//  - Init phase: walks init table mem_pkg::mem_iv and writes every {addr,data} entry into the memory.
//  - Run phase: round-robin arbitration of masters m0/m1 onto the one memory port.
//  - Sits between the two bus masters and the memory instance.

---
 rtl/mem_init_arb.sv | 208 ++++++++++++++++++++
 tb/tb_mem_init_arb.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_init_arb.sv
// Init sequencer and two-master round-robin arbiter for one single-port synchronous memory.
// Optional build macro MEM_INIT_ARB_READBACK_EN adds a readback check of the init table.

package mem_pkg;
  localparam int IV_MAX = 8;
  // Entry format: {addr[15:0], data[31:0]}
  localparam logic [47:0] mem_iv [IV_MAX] = '{
    48'h0000_AAAAAAAA,
    48'h0001_55555555,
    48'h0002_00000000,
    48'h0003_FFFFFFFF,
    48'h0004_77777777,
    48'h0005_88888888,
    48'h0006_EEEEEEEE,
    48'h0007_11111111
  };
endpackage

// state    | meaning
// INIT_WR  | writing one table entry per cycle
// INIT_CHK | reading back one table address per cycle (readback build only)
// CHK_WAIT | draining the final readback compare
// RUN      | init complete, masters arbitrated onto the memory port
module mem_init_arb #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int IV_N   = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wd,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rd,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wd,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wd,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rd,
  output logic              init_done,
  output logic              init_err
);

  localparam logic [1:0] INIT_WR  = 2'd0;
  localparam logic [1:0] INIT_CHK = 2'd1;
  localparam logic [1:0] CHK_WAIT = 2'd2;
  localparam logic [1:0] RUN      = 2'd3;

`ifdef MEM_INIT_ARB_READBACK_EN
  localparam logic [1:0] AFTER_WR = INIT_CHK;
`else
  localparam logic [1:0] AFTER_WR = RUN;
`endif

  localparam int IDX_W = (IV_N > 1) ? $clog2(IV_N) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(IV_N - 1);

  logic [1:0]        state;
  logic [IDX_W-1:0]  idx;
  logic [47:0]       iv_ent;
  logic              init_we_q;
  logic              init_re_q;
  logic [ADDR_W-1:0] init_addr_q;
  logic [DATA_W-1:0] init_wd_q;
  logic              init_done_q;
  logic              rr_q;
  logic              rv0_q;
  logic              rv1_q;
  logic [DATA_W-1:0] hold0_q;
  logic [DATA_W-1:0] hold1_q;

  assign iv_ent = mem_pkg::mem_iv[idx];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= INIT_WR;
      idx         <= '0;
      init_we_q   <= 1'b0;
      init_re_q   <= 1'b0;
      init_addr_q <= '0;
      init_wd_q   <= '0;
      init_done_q <= 1'b0;
    end else begin
      case (state)
        INIT_WR: begin
          init_we_q   <= 1'b1;
          init_re_q   <= 1'b0;
          init_addr_q <= iv_ent[32 +: ADDR_W];
          init_wd_q   <= iv_ent[0 +: DATA_W];
          if (idx == IDX_LAST) begin
            idx   <= '0;
            state <= AFTER_WR;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        INIT_CHK: begin
          // init_wd_q carries the expected data into the compare pipeline
          init_we_q   <= 1'b0;
          init_re_q   <= 1'b1;
          init_addr_q <= iv_ent[32 +: ADDR_W];
          init_wd_q   <= iv_ent[0 +: DATA_W];
          if (idx == IDX_LAST) begin
            idx   <= '0;
            state <= CHK_WAIT;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        CHK_WAIT: begin
          init_we_q <= 1'b0;
          init_re_q <= 1'b0;
          state     <= RUN;
        end
        RUN: begin
          init_we_q   <= 1'b0;
          init_re_q   <= 1'b0;
          init_done_q <= 1'b1;
        end
        default: state <= INIT_WR;
      endcase
    end
  end

`ifdef MEM_INIT_ARB_READBACK_EN
  logic              cmp_v_q;
  logic [DATA_W-1:0] cmp_exp_q;
  logic              err_q;

  // mem_rd is valid the cycle after mem_re, so compare one cycle behind the read
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cmp_v_q   <= 1'b0;
      cmp_exp_q <= '0;
      err_q     <= 1'b0;
    end else begin
      cmp_v_q   <= init_re_q;
      cmp_exp_q <= init_wd_q;
      if (cmp_v_q && (mem_rd != cmp_exp_q)) err_q <= 1'b1;
    end
  end

  assign init_err = err_q;
`else
  assign init_err = 1'b0;
`endif

  assign init_done = init_done_q;

  // rr_q names the last granted master; 1 = m1 so m0 wins the first tie
  assign m0_gnt = init_done_q & m0_req & (~m1_req | rr_q);
  assign m1_gnt = init_done_q & m1_req & (~m0_req | ~rr_q);

  always_comb begin
    mem_addr = '0;
    mem_wd   = '0;
    mem_we   = 1'b0;
    mem_re   = 1'b0;
    if (!init_done_q) begin
      mem_addr = init_addr_q;
      mem_wd   = init_wd_q;
      mem_we   = init_we_q;
      mem_re   = init_re_q;
    end else if (m0_gnt) begin
      mem_addr = m0_addr;
      mem_wd   = m0_wd;
      mem_we   = m0_we;
      mem_re   = ~m0_we;
    end else if (m1_gnt) begin
      mem_addr = m1_addr;
      mem_wd   = m1_wd;
      mem_we   = m1_we;
      mem_re   = ~m1_we;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rr_q    <= 1'b1;
      rv0_q   <= 1'b0;
      rv1_q   <= 1'b0;
      hold0_q <= '0;
      hold1_q <= '0;
    end else begin
      if (m0_gnt || m1_gnt) rr_q <= m1_gnt;
      rv0_q <= m0_gnt & ~m0_we;
      rv1_q <= m1_gnt & ~m1_we;
      if (rv0_q) hold0_q <= mem_rd;
      if (rv1_q) hold1_q <= mem_rd;
    end
  end

  assign m0_rvalid = rv0_q;
  assign m1_rvalid = rv1_q;
  assign m0_rd     = rv0_q ? mem_rd : hold0_q;
  assign m1_rd     = rv1_q ? mem_rd : hold1_q;

endmodule

// File: tb/tb_mem_init_arb.sv
// Directed bench for mem_init_arb with a behavioural single-port memory attached.
module tb_mem_init_arb;
  logic        clk = 1'b0;
  logic        resetn;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [15:0] m0_addr, m1_addr, mem_addr;
  logic [31:0] m0_wd, m1_wd, m0_rd, m1_rd, mem_wd, mem_rd;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic        mem_we, mem_re, init_done, init_err;

  int n_cmp = 0;
  int n_bad = 0;
  bit corrupt = 1'b0;

  logic [31:0] mdl [0:255];
  logic [31:0] rd_q = 32'h0;
  logic [31:0] exp_data [8] = '{32'hAAAAAAAA, 32'h55555555, 32'h00000000, 32'hFFFFFFFF,
                                32'h77777777, 32'h88888888, 32'hEEEEEEEE, 32'h11111111};

  always #5 clk = ~clk;

  mem_init_arb dut (
    .clk(clk), .resetn(resetn),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wd(m0_wd),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rd(m0_rd),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wd(m1_wd),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rd(m1_rd),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wd(mem_wd), .mem_re(mem_re),
    .mem_rd(mem_rd), .init_done(init_done), .init_err(init_err)
  );

  // Model memory; when corrupt is set, init-phase reads of address 2 return flipped data
  always @(posedge clk) begin
    if (mem_we) mdl[mem_addr[7:0]] <= mem_wd;
    if (mem_re) rd_q <= (corrupt && !init_done && mem_addr == 16'd2) ?
                        (mdl[mem_addr[7:0]] ^ 32'h0000_0001) : mdl[mem_addr[7:0]];
  end
  assign mem_rd = rd_q;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = 16'h0; m0_wd = 32'h0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = 16'h0; m1_wd = 32'h0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_mem_we"}, mem_we, 0);
    chk({tag, "_mem_re"}, mem_re, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_done"}, init_done, 0);
    chk({tag, "_err"}, init_err, 0);
    chk({tag, "_gnt"}, {m0_gnt, m1_gnt}, 0);
    chk({tag, "_rvalid"}, {m0_rvalid, m1_rvalid}, 0);
    chk({tag, "_rd"}, {m0_rd, m1_rd}, 0);
  endtask

  // Called at the negedge where resetn rises; ends in the first cycle with init_done expected high
  task automatic run_init(input bit err_exp);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("init_we", mem_we, 1);
      chk("init_addr", mem_addr, c);
      chk("init_wd", mem_wd, exp_data[c]);
      chk("init_done_low", init_done, 0);
    end
`ifdef MEM_INIT_ARB_READBACK_EN
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("chk_re", mem_re, 1);
      chk("chk_we", mem_we, 0);
      chk("chk_addr", mem_addr, c);
      chk("chk_done_low", init_done, 0);
      if (c == 3) chk("err_cycle11", init_err, 0);
      if (c == 4) chk("err_cycle12", init_err, err_exp);
    end
    @(negedge clk);
    chk("done_cycle16", init_done, 0);
    @(negedge clk);
    chk("done_cycle17", init_done, 1);
    chk("err_cycle17", init_err, err_exp);
`else
    @(negedge clk);
    chk("done_cycle8", init_done, 1);
    chk("err_tied0", init_err, 0);
`endif
    chk("run_idle_we", mem_we, 0);
    chk("run_idle_re", mem_re, 0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mdl[i] = 32'hDEAD0000 | i;
    idle_inputs();
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    resetn = 1'b1;

    // Test 1: init sequence
    run_init(1'b0);

    // Test 3: contention from a fresh init alternates m0, m1, m0, m1
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 16'd0;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 16'd1;
    #1;
    chk("rr1_gnt", {m0_gnt, m1_gnt}, 2'b10);
    chk("rr1_addr", mem_addr, 0);
    chk("rr1_re", mem_re, 1);
    @(negedge clk); #1;
    chk("rr2_gnt", {m0_gnt, m1_gnt}, 2'b01);
    chk("rr2_addr", mem_addr, 1);
    chk("rr2_m0_rvalid", m0_rvalid, 1);
    chk("rr2_m0_rd", m0_rd, 32'hAAAAAAAA);
    chk("rr2_m1_rvalid", m1_rvalid, 0);
    @(negedge clk); #1;
    chk("rr3_gnt", {m0_gnt, m1_gnt}, 2'b10);
    chk("rr3_m1_rvalid", m1_rvalid, 1);
    chk("rr3_m1_rd", m1_rd, 32'h55555555);
    chk("rr3_m0_rvalid", m0_rvalid, 0);
    @(negedge clk); #1;
    chk("rr4_gnt", {m0_gnt, m1_gnt}, 2'b01);

    // Test 2: single m0 read of addr 3
    @(negedge clk);
    idle_inputs();
    m0_req = 1'b1; m0_addr = 16'd3;
    #1;
    chk("rd3_gnt", {m0_gnt, m1_gnt}, 2'b10);
    chk("rd3_re", mem_re, 1);
    chk("rd3_addr", mem_addr, 3);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("rd3_rvalid", m0_rvalid, 1);
    chk("rd3_rd", m0_rd, 32'hFFFFFFFF);
    chk("rd3_m1_rvalid", m1_rvalid, 0);
    chk("idle_re", mem_re, 0);

    // Test 4: m1 writes addr 5, then m0 reads it back
    @(negedge clk);
    chk("rd3_rvalid_drop", m0_rvalid, 0);
    chk("rd3_rd_hold", m0_rd, 32'hFFFFFFFF);
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 16'd5; m1_wd = 32'h12345678;
    #1;
    chk("wr5_gnt", {m0_gnt, m1_gnt}, 2'b01);
    chk("wr5_we_re", {mem_we, mem_re}, 2'b10);
    chk("wr5_wd", mem_wd, 32'h12345678);
    @(negedge clk);
    idle_inputs();
    m0_req = 1'b1; m0_addr = 16'd5;
    #1;
    chk("raw5_gnt", {m0_gnt, m1_gnt}, 2'b10);
    chk("wr5_no_rvalid", m1_rvalid, 0);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("raw5_rvalid", m0_rvalid, 1);
    chk("raw5_rd", m0_rd, 32'h12345678);
    chk("raw5_idle", {mem_we, mem_re}, 2'b00);

    // Test 5/6: fresh reset, abort init at cycle 4, restart with addr 2 corrupted on readback
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("pre_abort_addr", mem_addr, c);
    end
    @(negedge clk);
    resetn = 1'b0;
    m0_req = 1'b1; m0_addr = 16'd3;
    #1;
    check_reset_outputs("abort");
    @(negedge clk);
    idle_inputs();
    corrupt = 1'b1;
    resetn = 1'b1;
`ifdef MEM_INIT_ARB_READBACK_EN
    run_init(1'b1);
`else
    run_init(1'b0);
`endif
    corrupt = 1'b0;

    m0_req = 1'b1; m0_addr = 16'd3;
    #1;
    chk("post_gnt", {m0_gnt, m1_gnt}, 2'b10);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("post_rvalid", m0_rvalid, 1);
    chk("post_rd", m0_rd, 32'hFFFFFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
